// File: rtl/fifo_level_if.sv
// Handshake/status bundle between a fifo_level instance and its user.
// Latency: none, wires only.
// Backpressure: the user observes full_flag/empty_flag before issuing write/read.
interface fifo_level_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_DEPTH = 1024
);
  localparam int CW = $clog2(DATA_DEPTH) + 1;

  logic                  flush;
  logic                  write;
  logic                  read;
  logic                  clear_err;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  empty_flag;
  logic                  full_flag;
  logic                  almost_empty;
  logic                  almost_full;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, write, read, clear_err, data_in,
    input  data_out, data_valid, empty_flag, full_flag,
           almost_empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  flush, write, read, clear_err, data_in,
    output data_out, data_valid, empty_flag, full_flag,
           almost_empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_level.sv
// Single-clock FIFO with occupancy count, level flags and sticky error flags.
// Latency: data_out/data_valid one cycle after an accepted read; flags track count on the same edge.
// Backpressure: writes dropped while full (overflow set), reads dropped while empty (underflow set).
module fifo_level #(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_DEPTH = 1024,
  parameter int AF_THRESH  = DATA_DEPTH - 4,
  parameter int AE_THRESH  = 4
) (
  input logic         clk,
  input logic         rst,
  fifo_level_if.slave bus
);
  localparam int AW = $clog2(DATA_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DATA_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_n;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  data_valid_q;
  logic                  empty_q;
  logic                  full_q;
  logic                  almost_empty_q;
  logic                  almost_full_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  ov_evt;
  logic                  un_evt;

  // Accept decisions and next occupancy; flush overrides any transfer.
  always_comb begin
    wr_acc  = bus.write & ~full_q  & ~bus.flush & ~rst;
    rd_acc  = bus.read  & ~empty_q & ~bus.flush & ~rst;
    ov_evt  = bus.write & full_q;
    un_evt  = bus.read  & empty_q;
    count_n = count_q;
    if (bus.flush) begin
      count_n = '0;
    end else if (wr_acc && !rd_acc) begin
      count_n = count_q + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_n = count_q - CW'(1);
    end
  end

  // Storage array; left unreset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  // Pointers, count, read data and level flags (flags from next-state count).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count_q        <= '0;
      data_out_q     <= '0;
      data_valid_q   <= 1'b0;
      empty_q        <= 1'b1;
      full_q         <= 1'b0;
      almost_empty_q <= 1'b1;
      almost_full_q  <= 1'b0;
    end else begin
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
        if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      end
      if (rd_acc) data_out_q <= mem[rd_ptr];
      data_valid_q   <= rd_acc;
      count_q        <= count_n;
      empty_q        <= (count_n == '0);
      full_q         <= (count_n == DEPTH_C);
      almost_empty_q <= (count_n <= AE_C);
      almost_full_q  <= (count_n >= AF_C);
    end
  end

  // Sticky errors: a new event wins over clear_err in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (ov_evt)             overflow_q  <= 1'b1;
      else if (bus.clear_err) overflow_q  <= 1'b0;
      if (un_evt)             underflow_q <= 1'b1;
      else if (bus.clear_err) underflow_q <= 1'b0;
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.data_valid   = data_valid_q;
  assign bus.count        = count_q;
  assign bus.empty_flag   = empty_q;
  assign bus.full_flag    = full_q;
  assign bus.almost_empty = almost_empty_q;
  assign bus.almost_full  = almost_full_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule
